// File: rtl/irq_pulse_gen.sv
// irq_pulse_gen: memory-mapped interrupt pulse source on the processor data bus.
// Software programs a delay, a pulse width and a line mask. It then starts a
// one-shot or periodic train of pulses on interrupts[7:0].
//
// Register window (16 bytes at BASE, selected by dataadr[3:2]):
//   0 CTRL   : bit0 start (reads 0), bit1 periodic, bits15:8 line mask
//   1 DELAY  : CNTW-bit delay count in cycles
//   2 WIDTH  : bits7:0 pulse width in cycles (0 behaves as 1)
//   3 STATUS : bit0 busy, bits15:8 saturating pulse count; any write clears it
//
// Ports:
//   ph1        clock, rising edge
//   reset_b    asynchronous active-low reset
//   memwrite   store strobe
//   dataadr    data address
//   writedata  store data
//   readdata   combinational register read data for dataadr
//   interrupts registered interrupt lines to the core
//   busy       high while a sequence is running (not IDLE)
module irq_pulse_gen #(
  parameter logic [31:0] BASE = 32'hbfc00100,
  parameter int          CNTW = 32
) (
  input  logic        ph1,
  input  logic        reset_b,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  interrupts,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PULSE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   delay_q, delay_d;
  logic [7:0]        width_q, width_d;
  logic              ctrl_per_q, ctrl_per_d;
  logic [7:0]        ctrl_mask_q, ctrl_mask_d;
  logic [CNTW-1:0]   dcnt_q, dcnt_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [7:0]        irq_q, irq_d;
  logic [7:0]        run_mask_q, run_mask_d;
  logic              run_per_q, run_per_d;
  logic [7:0]        count_q, count_d;

  logic              in_window;
  logic              wr_ctrl, wr_delay, wr_width, wr_status;
  logic              pulse_entry;
  logic              unused_addr_bits;

  // Byte offset bits are ignored for both loads and stores.
  assign unused_addr_bits = ^dataadr[1:0];

  assign in_window = (dataadr[31:4] == BASE[31:4]);
  assign wr_ctrl   = memwrite && in_window && (dataadr[3:2] == 2'd0);
  assign wr_delay  = memwrite && in_window && (dataadr[3:2] == 2'd1);
  assign wr_width  = memwrite && in_window && (dataadr[3:2] == 2'd2);
  assign wr_status = memwrite && in_window && (dataadr[3:2] == 2'd3);

  assign interrupts = irq_q;
  assign busy       = (state_q != ST_IDLE);

  // Programmable registers
  always_comb begin
    ctrl_per_d  = ctrl_per_q;
    ctrl_mask_d = ctrl_mask_q;
    delay_d     = delay_q;
    width_d     = width_q;
    if (wr_ctrl) begin
      ctrl_per_d  = writedata[1];
      ctrl_mask_d = writedata[15:8];
    end
    if (wr_delay) delay_d = CNTW'(writedata);
    if (wr_width) width_d = writedata[7:0];
  end

  // Sequencer: the running counters only reload from DELAY/WIDTH at start,
  // pulse entry or periodic re-arm, so register writes mid-run are shadowed.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = wcnt_q;
    irq_d       = irq_q;
    run_mask_d  = run_mask_q;
    run_per_d   = run_per_q;
    pulse_entry = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (dcnt_q == '0) begin
          state_d     = ST_PULSE;
          wcnt_d      = width_q;
          irq_d       = run_mask_q;
          pulse_entry = 1'b1;
        end else begin
          dcnt_d = dcnt_q - CNTW'(1);
        end
      end
      ST_PULSE: begin
        // A width of 0 or 1 both give a single-cycle pulse.
        if (wcnt_q <= 8'd1) begin
          irq_d = 8'h00;
          if (run_per_q) begin
            state_d = ST_WAIT;
            dcnt_d  = delay_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      default: ;
    endcase

    // A CTRL store overrides whatever the sequencer would have done this edge.
    if (wr_ctrl) begin
      if (writedata[0]) begin
        state_d     = ST_WAIT;
        dcnt_d      = delay_q;
        run_mask_d  = writedata[15:8];
        run_per_d   = writedata[1];
        irq_d       = 8'h00;
        pulse_entry = 1'b0;
      end else if (state_q != ST_IDLE) begin
        state_d     = ST_IDLE;
        irq_d       = 8'h00;
        pulse_entry = 1'b0;
      end
    end
  end

  // Clear happens before the increment so a coincident pulse still counts.
  always_comb begin
    count_d = wr_status ? 8'h00 : count_q;
    if (pulse_entry && (count_d != 8'hff)) count_d = count_d + 8'd1;
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= ST_IDLE;
      delay_q     <= '0;
      width_q     <= 8'h00;
      ctrl_per_q  <= 1'b0;
      ctrl_mask_q <= 8'h00;
      dcnt_q      <= '0;
      wcnt_q      <= 8'h00;
      irq_q       <= 8'h00;
      run_mask_q  <= 8'h00;
      run_per_q   <= 1'b0;
      count_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      ctrl_per_q  <= ctrl_per_d;
      ctrl_mask_q <= ctrl_mask_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      irq_q       <= irq_d;
      run_mask_q  <= run_mask_d;
      run_per_q   <= run_per_d;
      count_q     <= count_d;
    end
  end

  // Load data; addresses outside the window read as 0.
  always_comb begin
    readdata = 32'h0;
    if (in_window) begin
      case (dataadr[3:2])
        2'd0:    readdata = {16'h0, ctrl_mask_q, 6'h0, ctrl_per_q, 1'b0};
        2'd1:    readdata = 32'(delay_q);
        2'd2:    readdata = {24'h0, width_q};
        default: readdata = {16'h0, count_q, 7'h0, busy};
      endcase
    end
  end

endmodule

// File: doc/irq_pulse_gen.md
Name: irq_pulse_gen

Overview:
- Memory-mapped interrupt source on the processor data bus.
- Responds to processor stores (memwrite/dataadr/writedata) and answers loads with readdata.
- Drives the core's interrupts[7:0] input with programmable-delay, programmable-width pulses, one-shot or periodic.
- Lets self-checking programs schedule their own interrupts.

Parameters:
- BASE, 32'hbfc00100, register window base; must be 16-byte aligned.
- CNTW, 32, width of the delay down-counter.

Ports:
- ph1  input  1  clock; all state updates on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- memwrite  input  1  processor store strobe.
- dataadr  input  32  processor data address.
- writedata  input  32  processor store data.
- readdata  output  32  register read data; combinational from dataadr.
- interrupts  output  8  registered interrupt lines to the core.
- busy  output  1  high while not IDLE.

Behaviour:
- Decode: hit = memwrite & (dataadr[31:4] == BASE[31:4]). dataadr[3:2] selects the register; dataadr[1:0] is ignored.
- Reg 0, CTRL (RW):
  - bit0 start (reads 0).
  - bit1 periodic.
  - bits15:8 line mask.
  - Other bits read 0.
- Reg 1, DELAY (RW): CNTW-bit cycle count.
- Reg 2, WIDTH (RW): bits7:0 pulse width; a value of 0 behaves as 1.
- Reg 3, STATUS:
  - Read: bit0 busy, bits15:8 pulse count (saturates at 255).
  - Any write clears the pulse count.
- Reset, asynchronous, while reset_b=0:
  - State IDLE; all registers 0.
  - interrupts=0, busy=0, count=0.
  - readdata follows the registers (so reads 0 for every register).
- FSM states: IDLE, WAIT, PULSE.
- CTRL write with start=1 at edge N:
  - From any state, go to WAIT.
  - Delay counter loads DELAY (the new value if DELAY was written before).
  - Latch mask and periodic.
  - interrupts=0 at N.
- WAIT, each edge:
  - If counter==0, go to PULSE, load width counter from WIDTH, interrupts<=mask, increment count.
  - Else decrement counter.
  - interrupts therefore rise at edge N+1+DELAY.
- PULSE, each edge:
  - If width counter<=1, deassert interrupts.
  - Then go to WAIT with counter reloaded from DELAY if periodic, else go to IDLE.
  - Otherwise decrement the width counter.
  - interrupts are high for exactly max(WIDTH,1) cycles.
- CTRL write with start=0 while busy: abort to IDLE; interrupts=0 at the next edge; count unchanged.
- DELAY or WIDTH writes while busy: no effect on the running counters; used at the next reload.
- Periodic low time between pulses is DELAY+1 cycles.
- Simultaneous STATUS write and pulse-count increment on the same edge: count ends at 1.
- Count saturation: stays at 255, no wrap.
- mask=0: FSM sequences normally and count increments, but interrupts stay 0.
- Non-hit stores: ignored.
- reset_b asserted mid-pulse: interrupts drop immediately (asynchronous), state IDLE.

Test Plan:
- Reset/idle: reset_b=0 mid-sequence.
  - Expect interrupts=00, busy=0 immediately.
  - All four register reads return 0 after release.
- One-shot timing: DELAY=5, WIDTH=3, CTRL=0x0201 written at edge N.
  - Expect interrupts=02 during edges N+6..N+8, then 00.
  - busy=0 from N+9; STATUS reads 0x0100.
- Periodic: DELAY=2, WIDTH=0, CTRL=0x0103.
  - Expect 1-cycle pulses on line 0 every 4 cycles.
  - After 10 pulses STATUS[15:8]=10.
  - CTRL=0 write: interrupts=00 next edge, busy=0.
- Restart and register shadowing:
  - Write DELAY=100 during WAIT of a DELAY=50 run: pulse still at 51 cycles.
  - Write CTRL start=1 mid-WAIT: counter reloads to 100, pulse 101 cycles later.
- Decode: store to BASE+0x10 and to BASE+0x3 (equivalent to offset 0 after dropping dataadr[1:0]).
  - First is ignored; second writes CTRL.
  - Readdata at BASE+0x4 returns the DELAY value.
- Boundaries:
  - STATUS write coincident with pulse entry: count=1.
  - 300 periodic pulses: count=255.
  - DELAY=0 one-shot: interrupts high at N+1.
